// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for the sequential ALU.
// Configuration macro ALU_MUL_EN (see seq_alu.sv) selects the iterative multiplier.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    localparam int NUM_FLAGS = 4;
    localparam int FLAG_Z    = 0;
    localparam int FLAG_N    = 1;
    localparam int FLAG_C    = 2;
    localparam int FLAG_V    = 3;

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result bus of the sequential ALU: valid/ready on both the issue and result sides.
// The slave modport is the ALU, the master modport is the issuing/consuming pipeline.
interface seq_alu_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       alu_control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, a, b, alu_control, out_ready,
        input  in_ready, out_valid, result, zero, negative, carry, overflow
    );

    modport slave (
        input  in_valid, a, b, alu_control, out_ready,
        output in_ready, out_valid, result, zero, negative, carry, overflow
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one partial product per cycle over WIDTH cycles.
// Only compiled when ALU_MUL_EN is defined; done_o marks the last step with the final product.
`ifdef ALU_MUL_EN
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);

    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic               lastStep;

    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    // The product is taken combinationally on the last step so the top can register it on the same edge.
    assign lastStep  = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign done_o    = lastStep;
    assign product_o = acc_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (lastStep) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes and a one-deep, pass-through output register.
// Define ALU_MUL_EN to run op 111 on the iterative multiplier; otherwise MUL returns 0 in one cycle.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst_n,
    seq_alu_if.slave   bus
);
    import alu_pkg::*;

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH'(WIDTH);

    state_e                 state_q;
    state_e                 state_d;
    logic                   outValid_q;
    logic                   outValid_d;
    logic [WIDTH-1:0]       result_q;
    logic [WIDTH-1:0]       result_d;
    logic [NUM_FLAGS-1:0]   flags_q;
    logic [NUM_FLAGS-1:0]   flags_d;

    logic                   inReady;
    logic                   accept;
    logic                   isMulIter;
    logic                   mulDone;
    logic                   loadAlu;
    logic                   loadOut;

    logic [WIDTH:0]         addSum;
    logic [WIDTH-1:0]       subDiff;
    logic                   borrow;
    logic                   sltBit;
    logic                   bigShift;
    logic [SHAMT_W-1:0]     shamt;
    logic [WIDTH-1:0]       aluResult;
    logic                   aluCarry;
    logic                   aluOverflow;
    logic [WIDTH-1:0]       loadResult;
    logic                   loadCarry;
    logic                   loadOverflow;

    assign accept = bus.in_valid && inReady;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] mulProduct;

    assign isMulIter = (bus.alu_control == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) uMul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (accept && isMulIter),
        .a_i       (bus.a),
        .b_i       (bus.b),
        .done_o    (mulDone),
        .product_o (mulProduct)
    );
`else
    assign isMulIter = 1'b0;
    assign mulDone   = 1'b0;
`endif

    assign addSum   = {1'b0, bus.a} + {1'b0, bus.b};
    assign subDiff  = bus.a - bus.b;
    assign borrow   = (bus.a < bus.b);
    assign sltBit   = ($signed(bus.a) < $signed(bus.b));
    assign shamt    = bus.b[SHAMT_W-1:0];
    // The whole of b is compared so that out-of-range amounts clear the result instead of wrapping.
    assign bigShift = (bus.b >= WIDTH_VAL);

    always_comb begin
        aluResult   = '0;
        aluCarry    = 1'b0;
        aluOverflow = 1'b0;
        case (bus.alu_control)
            OP_ADD: begin
                aluResult   = addSum[WIDTH-1:0];
                aluCarry    = addSum[WIDTH];
                aluOverflow = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                              (addSum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_OR:  aluResult = bus.a | bus.b;
            OP_AND: aluResult = bus.a & bus.b;
            OP_SLL: aluResult = bigShift ? '0 : (bus.a << shamt);
            OP_SUB: begin
                aluResult   = subDiff;
                aluCarry    = borrow;
                aluOverflow = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                              (subDiff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SRL: aluResult = bigShift ? '0 : (bus.a >> shamt);
            OP_SLT: begin
                aluResult = {{(WIDTH-1){1'b0}}, sltBit};
                aluCarry  = borrow;
            end
            OP_MUL: aluResult = '0;
        endcase
    end

    always_comb begin
        loadResult   = aluResult;
        loadCarry    = aluCarry;
        loadOverflow = aluOverflow;
`ifdef ALU_MUL_EN
        if (mulDone) begin
            loadResult   = mulProduct[WIDTH-1:0];
            loadCarry    = |mulProduct[2*WIDTH-1:WIDTH];
            loadOverflow = 1'b0;
        end
`endif
    end

    assign loadAlu = accept && !isMulIter;
    assign loadOut = loadAlu || mulDone;

    // A new result takes priority over draining, which gives back-to-back issue while out_ready is high.
    always_comb begin
        outValid_d = outValid_q;
        result_d   = result_q;
        flags_d    = flags_q;
        if (loadOut) begin
            outValid_d      = 1'b1;
            result_d        = loadResult;
            flags_d[FLAG_Z] = (loadResult == '0);
            flags_d[FLAG_N] = loadResult[WIDTH-1];
            flags_d[FLAG_C] = loadCarry;
            flags_d[FLAG_V] = loadOverflow;
        end else if (outValid_q && bus.out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            outValid_q <= outValid_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && isMulIter) state_d = ST_MUL;
            ST_MUL:  if (mulDone)             state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        inReady = rst_n && (state_q == ST_IDLE) && (!outValid_q || bus.out_ready);
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid_q;
    assign bus.result    = result_q;
    assign bus.zero      = flags_q[FLAG_Z];
    assign bus.negative  = flags_q[FLAG_N];
    assign bus.carry     = flags_q[FLAG_C];
    assign bus.overflow  = flags_q[FLAG_V];

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed vectors push expected results, a negedge monitor pops them.
// MUL expectations follow ALU_MUL_EN, which must be set the same way as for the RTL.
module tb_seq_alu;
    import alu_pkg::*;

`ifdef ALU_MUL_EN
    localparam int MUL_LAT = 33;
`else
    localparam int MUL_LAT = 1;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    logic clk;
    logic rst_n;

    seq_alu_if #(.WIDTH(32)) bus ();

    seq_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          assertCount = 0;
    int          failCount   = 0;
    int          outCount    = 0;
    int          cycle       = 0;
    int          lastWait    = 0;
    string       expName[$];
    logic [31:0] expRes[$];
    logic [3:0]  expFlags[$];
    string       monName;
    logic [31:0] monRes;
    logic [3:0]  monFlags;
    vec_t        vecs[14];
    vec_t        mulVecs[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] res, input logic [3:0] fl);
        int waited;
        waited = 0;
        expName.push_back(name);
        expRes.push_back(res);
        expFlags.push_back(fl);
        bus.in_valid    = 1'b1;
        bus.alu_control = op;
        bus.a           = a;
        bus.b           = b;
        #1;
        while (bus.in_ready !== 1'b1 && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL %s_accept: in_ready still %b after %0d cycles, expected 1", name, bus.in_ready, waited);
        end
        @(posedge clk);
        #1;
        lastWait = waited;
        // Operands are scrambled after the accept edge; the ALU must have captured them already.
        bus.in_valid    = 1'b0;
        bus.alu_control = 3'($urandom);
        bus.a           = $urandom;
        bus.b           = $urandom;
    endtask

    // Flags are compared packed as {zero, negative, carry, overflow}.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            outCount++;
            if (expRes.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_output: result 0x%0h presented, expected no output", bus.result);
            end else begin
                monName  = expName.pop_front();
                monRes   = expRes.pop_front();
                monFlags = expFlags.pop_front();
                checkOutput({monName, "_result"}, 64'(bus.result), 64'(monRes));
                checkOutput({monName, "_flags"},
                            64'({bus.zero, bus.negative, bus.carry, bus.overflow}), 64'(monFlags));
            end
        end
    end

    initial begin
        int cycleStart;
        int outStart;
        int n;
        int busyViol;
        int sawValid;

        vecs[0]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101};
        vecs[1]  = '{OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1000};
        vecs[2]  = '{OP_SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b0110};
        vecs[3]  = '{OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000};
        vecs[4]  = '{OP_SLL, 32'h0000_0001, 32'd31,        32'h8000_0000, 4'b0100};
        vecs[5]  = '{OP_SRL, 32'h8000_0000, 32'd32,        32'h0000_0000, 4'b1000};
        vecs[6]  = '{OP_OR,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 4'b0100};
        vecs[7]  = '{OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 4'b0000};
        vecs[8]  = '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0001};
        vecs[9]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010};
        vecs[10] = '{OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1010};
        vecs[11] = '{OP_SRL, 32'h8000_0000, 32'd4,         32'h0800_0000, 4'b0000};
        vecs[12] = '{OP_SLL, 32'h0000_0003, 32'd33,        32'h0000_0000, 4'b1000};
        vecs[13] = '{OP_ADD, 32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0101};
`ifdef ALU_MUL_EN
        mulVecs[0] = '{OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b1010};
        mulVecs[1] = '{OP_MUL, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 4'b0000};
        mulVecs[2] = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0010};
`else
        mulVecs[0] = '{OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b1000};
        mulVecs[1] = '{OP_MUL, 32'h0000_1234, 32'h0000_0010, 32'h0000_0000, 4'b1000};
        mulVecs[2] = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1000};
`endif

        rst_n           = 1'b0;
        bus.out_ready   = 1'b1;
        bus.in_valid    = 1'b0;
        bus.alu_control = 3'b000;
        bus.a           = '0;
        bus.b           = '0;

        $display("[TB] reset");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_result", 64'(bus.result), 64'd0);
        checkOutput("rst_flags", 64'({bus.zero, bus.negative, bus.carry, bus.overflow}), 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

        $display("[TB] back-to-back directed vectors");
        cycleStart = cycle;
        outStart   = outCount;
        for (int i = 0; i < 14; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl);
            checkOutput($sformatf("vec%0d_stall", i), 64'(lastWait), 64'd0);
        end
        checkOutput("b2b_cycles", 64'(cycle - cycleStart), 64'd14);
        @(negedge clk);
        #1;
        checkOutput("b2b_outputs", 64'(outCount - outStart), 64'd14);
        @(posedge clk);
        #1;

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus("bp_add", OP_ADD, 32'd2, 32'd3, 32'd5, 4'b0000);
        bus.in_valid    = 1'b1;
        bus.alu_control = OP_ADD;
        bus.a           = 32'd10;
        bus.b           = 32'd20;
        expName.push_back("bp_next");
        expRes.push_back(32'd30);
        expFlags.push_back(4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_hold%0d_result", i), 64'(bus.result), 64'd5);
            checkOutput($sformatf("bp_hold%0d_valid", i), 64'(bus.out_valid), 64'd1);
            checkOutput($sformatf("bp_hold%0d_in_ready", i), 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("bp_next_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("bp_next_result", 64'(bus.result), 64'd30);
        @(posedge clk);
        #1;

        $display("[TB] multiply");
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("mul%0d", i), mulVecs[i].op, mulVecs[i].a, mulVecs[i].b,
                          mulVecs[i].res, mulVecs[i].fl);
            n        = 1;
            busyViol = 0;
            while (bus.out_valid !== 1'b1 && n < 100) begin
                if (bus.in_ready !== 1'b0) busyViol++;
                @(posedge clk);
                #1;
                n++;
            end
            checkOutput($sformatf("mul%0d_latency", i), 64'(n), 64'(MUL_LAT));
            checkOutput($sformatf("mul%0d_busy_in_ready", i), 64'(busyViol), 64'd0);
        end

`ifdef ALU_MUL_EN
        $display("[TB] reset during multiply");
        bus.in_valid    = 1'b1;
        bus.alu_control = OP_MUL;
        bus.a           = 32'd3;
        bus.b           = 32'd4;
        #1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        sawValid = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) sawValid++;
        end
        checkOutput("abort_no_output", 64'(sawValid), 64'd0);
`endif

        $display("[TB] reset with held output");
        @(posedge clk);
        #1;
        bus.out_ready   = 1'b0;
        bus.in_valid    = 1'b1;
        bus.alu_control = OP_ADD;
        bus.a           = 32'd1;
        bus.b           = 32'd1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("held_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("held_result", 64'(bus.result), 64'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst2_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("rst2_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst2_result", 64'(bus.result), 64'd0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;

        applyStimulus("recover_add", OP_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 64'(expRes.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
